// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store port: one access at a time,
// WAIT_CYCLES wait states, byte/half/word lanes with load extension and error reporting.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  DMType,
    output logic [31:0] Data_out,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int unsigned CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF_S = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE_S = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [2:0]         type_q, type_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [31:0]        dout_q, dout_d;

    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               req_rd, req_wr;
    logic [31:0]        req_addr, req_wdata;
    logic [2:0]         req_type;
    logic [31:0]        off;
    logic [IDX_W-1:0]   idx;
    logic               in_range, misalign, type_bad, acc_err;
    logic [31:0]        rd_word, load_val, wr_word;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [3:0]         be;
    logic               commit;

    // In IDLE the live inputs describe the access (needed when WAIT_CYCLES is 0).
    always_comb begin
        req_rd    = rd_q;
        req_wr    = wr_q;
        req_addr  = addr_q;
        req_wdata = wdata_q;
        req_type  = type_q;
        if (state_q == ST_IDLE) begin
            req_rd    = mem_r;
            req_wr    = mem_w;
            req_addr  = Addr_in;
            req_wdata = Data_in;
            req_type  = DMType;
        end
    end

    // Address decode, legality checks, load extraction and store lane merge.
    always_comb begin
        off      = req_addr - BASE_ADDR;
        idx      = off[IDX_W+1:2];
        in_range = {2'b00, off[31:2]} < 32'(DEPTH_WORDS);
        type_bad = req_type > DM_BYTE_U;
        misalign = 1'b0;
        case (req_type)
            DM_WORD:              misalign = off[1:0] != 2'b00;
            DM_HALF_S, DM_HALF_U: misalign = off[0];
            default:              misalign = 1'b0;
        endcase
        acc_err = (req_rd & req_wr) | type_bad | misalign | ~in_range;

        rd_word = in_range ? mem_q[idx] : 32'h0;
        case (off[1:0])
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = off[1] ? rd_word[31:16] : rd_word[15:0];

        load_val = 32'h0;
        wr_word  = req_wdata;
        be       = 4'h0;
        case (req_type)
            DM_WORD: begin
                load_val = rd_word;
                be       = 4'hF;
            end
            DM_HALF_S, DM_HALF_U: begin
                load_val = (req_type == DM_HALF_S) ? {{16{half_sel[15]}}, half_sel}
                                                   : {16'h0, half_sel};
                wr_word  = {2{req_wdata[15:0]}};
                be       = off[1] ? 4'hC : 4'h3;
            end
            DM_BYTE_S, DM_BYTE_U: begin
                load_val = (req_type == DM_BYTE_S) ? {{24{byte_sel[7]}}, byte_sel}
                                                   : {24'h0, byte_sel};
                wr_word  = {4{req_wdata[7:0]}};
                be       = 4'(4'b0001 << off[1:0]);
            end
            default: begin
                load_val = 32'h0;
                be       = 4'h0;
            end
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        type_d  = type_q;
        dout_d  = dout_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_r | mem_w) begin
                    rd_d    = mem_r;
                    wr_d    = mem_w;
                    addr_d  = Addr_in;
                    wdata_d = Data_in;
                    type_d  = DMType;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(CNT_INIT);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        commit  = (state_d == ST_RESP) && (state_q != ST_RESP);
        ready_d = state_d == ST_RESP;
        busy_d  = state_d != ST_IDLE;
        err_d   = commit & acc_err;
        if (commit && req_rd) begin
            dout_d = acc_err ? 32'h0 : load_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            type_q  <= 3'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            type_q  <= type_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            dout_q  <= dout_d;
        end
    end

    // Storage is never cleared; a store held in reset at its commit edge is dropped.
    always_ff @(posedge clk) begin
        if (reset && commit && req_wr && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    assign Data_out = dout_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder against a byte-addressed reference model,
// plus directed lane/error/reset cases and throughput checks at WAIT_CYCLES 0 and 3.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WAITC = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_r, mem_w;
    logic [31:0] Addr_in, Data_in;
    logic [2:0]  DMType;
    logic [31:0] Data_out;
    logic        ready, err, busy;

    logic        tp_r;
    logic [31:0] tp_addr, tp_data;
    logic [2:0]  tp_type;
    logic [31:0] d0_out, d3_out;
    logic        r0, e0, b0, r3, e3, b3;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_dout;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w), .Addr_in(Addr_in),
        .Data_in(Data_in), .DMType(DMType), .Data_out(Data_out), .ready(ready),
        .err(err), .busy(busy)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_w0 (
        .clk(clk), .reset(reset), .mem_r(tp_r), .mem_w(1'b0), .Addr_in(tp_addr),
        .Data_in(tp_data), .DMType(tp_type), .Data_out(d0_out), .ready(r0),
        .err(e0), .busy(b0)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_w3 (
        .clk(clk), .reset(reset), .mem_r(tp_r), .mem_w(1'b0), .Addr_in(tp_addr),
        .Data_in(tp_data), .DMType(tp_type), .Data_out(d3_out), .ready(r3),
        .err(e3), .busy(b3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access through the WAIT_CYCLES=1 instance; expectations come from ref_mem.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] typ);
        logic [31:0] word, val;
        logic        e;
        int          w, lane, n;
        w    = int'(addr >> 2);
        lane = int'(addr % 4);
        e = (rd && wr) || (typ > 3'd4) || (addr >= DEPTH * 4)
            || (typ == 3'd0 && lane != 0) || ((typ == 3'd1 || typ == 3'd2) && (lane % 2) != 0);
        word = e ? 32'h0 : ref_mem[w];
        val  = 32'h0;
        case (typ)
            3'd0: val = word;
            3'd1: begin val = (word >> (8 * lane)) & 32'hFFFF; if (val >= 32'h8000) val = val - 32'h10000; end
            3'd2: val = (word >> (8 * lane)) & 32'hFFFF;
            3'd3: begin val = (word >> (8 * lane)) & 32'hFF; if (val >= 32'h80) val = val - 32'h100; end
            3'd4: val = (word >> (8 * lane)) & 32'hFF;
            default: val = 32'h0;
        endcase
        if (rd) exp_dout = e ? 32'h0 : val;

        @(negedge clk);
        mem_r = rd; mem_w = wr; Addr_in = addr; Data_in = data; DMType = typ;
        @(negedge clk);
        mem_r = 1'b0; mem_w = 1'b0;
        Addr_in = $urandom; Data_in = $urandom; DMType = 3'($urandom);
        n = 1;
        check("busy_wait", 32'(busy), 32'(1));
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(WAITC + 1));
        check("err", 32'(err), 32'(e));
        check("dout", Data_out, exp_dout);

        if (wr && !e) begin
            for (int b = 0; b < 4; b++) begin
                logic [7:0] nb;
                nb = data[8*(b - lane) +: 8];
                if (typ == 3'd0) ref_mem[w][8*b +: 8] = data[8*b +: 8];
                else if ((typ == 3'd1 || typ == 3'd2) && b / 2 == lane / 2)
                    ref_mem[w][8*b +: 8] = (b % 2 == 0) ? data[7:0] : data[15:8];
                else if ((typ == 3'd3 || typ == 3'd4) && b == lane)
                    ref_mem[w][8*b +: 8] = data[7:0];
                else if (nb == nb) ref_mem[w][8*b +: 8] = ref_mem[w][8*b +: 8];
            end
        end
    endtask

    initial begin
        int q0[$];
        int q3[$];
        logic [31:0] a;
        logic [2:0]  t;
        int k;

        reset = 1'b0;
        mem_r = 1'b0; mem_w = 1'b0; Addr_in = 32'h0; Data_in = 32'h0; DMType = 3'h0;
        tp_r = 1'b0; tp_addr = 32'h0; tp_data = 32'h0; tp_type = 3'h0;
        exp_dout = 32'h0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_dout", Data_out, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 64; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, 3'd0);

        // Directed lane and error cases.
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 3'd0);
        check("dir_word", Data_out, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'h11, 32'h00000080, 3'd3);
        access(1'b1, 1'b0, 32'h10, 32'h0, 3'd0);
        check("dir_bytelane", Data_out, 32'hDEAD80EF);
        access(1'b1, 1'b0, 32'h11, 32'h0, 3'd3);
        check("dir_byte_s", Data_out, 32'hFFFFFF80);
        access(1'b1, 1'b0, 32'h11, 32'h0, 3'd4);
        check("dir_byte_u", Data_out, 32'h00000080);
        access(1'b0, 1'b1, 32'h12, 32'h00001234, 3'd1);
        access(1'b1, 1'b0, 32'h12, 32'h0, 3'd1);
        check("dir_half_s", Data_out, 32'h00001234);
        access(1'b1, 1'b0, 32'h13, 32'h0, 3'd1);
        check("dir_half_mis_err", 32'(err), 32'(1));
        check("dir_half_mis_dout", Data_out, 32'h0);
        access(1'b1, 1'b0, 32'h4002, 32'h0, 3'd0);
        check("dir_word_mis", 32'(err), 32'(1));
        access(1'b1, 1'b0, DEPTH * 4, 32'h0, 3'd0);
        check("dir_range", 32'(err), 32'(1));
        access(1'b1, 1'b1, 32'h10, 32'h55555555, 3'd0);
        check("dir_both", 32'(err), 32'(1));
        access(1'b1, 1'b0, 32'h10, 32'h0, 3'd0);
        check("dir_both_mem", Data_out, 32'h1234_80EF);
        access(1'b1, 1'b0, 32'h10, 32'h0, 3'd7);
        check("dir_type7", 32'(err), 32'(1));

        // Reset in the middle of a store's wait state.
        @(negedge clk);
        mem_w = 1'b1; Addr_in = 32'h20; Data_in = 32'hA5A5A5A5; DMType = 3'd0;
        @(negedge clk);
        mem_w = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_err", 32'(err), 32'(0));
        check("mid_rst_dout", Data_out, 32'h0);
        exp_dout = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        access(1'b1, 1'b0, 32'h20, 32'h0, 3'd0);

        // Random traffic, mostly aligned and in range.
        for (int i = 0; i < 250; i++) begin
            t = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (t == 3'd0) a = a & ~32'h3;
                else if (t == 3'd1 || t == 3'd2) a = a & ~32'h1;
            end
            k = $urandom_range(0, 11);
            if (k == 0) a = 32'(DEPTH * 4) + (a & 32'hC);
            else if (k == 1) a = 32'hFFFF_FFF0 + (a & 32'hC);
            k = $urandom_range(0, 19);
            if (k == 0) access(1'b1, 1'b1, a, $urandom, t);
            else if (k < 10) access(1'b0, 1'b1, a, $urandom, t);
            else access(1'b1, 1'b0, a, $urandom, t);
        end

        // Held load request on the WAIT_CYCLES 0 and 3 instances.
        @(negedge clk);
        tp_r = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (r0) q0.push_back(c);
            if (r3) q3.push_back(c);
            check("tp0_busy", 32'(b0), 32'(r0));
        end
        tp_r = 1'b0;
        check("tp0_count", 32'(q0.size()), 32'(20));
        check("tp3_count", 32'(q3.size()), 32'(8));
        if (q0.size() > 0) check("tp0_first", 32'(q0[0]), 32'(1));
        if (q3.size() > 0) check("tp3_first", 32'(q3[0]), 32'(4));
        for (int i = 1; i < q0.size(); i++) check("tp0_period", 32'(q0[i] - q0[i-1]), 32'(2));
        for (int i = 1; i < q3.size(); i++) check("tp3_period", 32'(q3[i] - q3[i-1]), 32'(5));

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
